change_event_logger: RTL and testbench



---
 rtl/evlog_pkg.sv | 18 +
 rtl/evlog_fifo.sv | 36 +++
 rtl/change_event_logger.sv | 95 +++++++++
 tb/tb_change_event_logger.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/evlog_pkg.sv
// evlog_pkg: shared types, defaults and drop-counter helpers for the change event logger
package evlog_pkg;
  localparam int DEF_NSIG  = 12;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DROP_W    = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  typedef struct packed {
    logic [DEF_TS_W-1:0]          t;
    logic [$clog2(DEF_NSIG)-1:0]  index;
    logic                         value;
  } ev_rec_t;
  function automatic logic [DROP_W-1:0] drop_add(input logic [DROP_W-1:0] a, input logic [31:0] n);
    logic [32:0] s;
    s = 33'(a) + 33'(n);
    return (s > 33'(DROP_MAX)) ? DROP_MAX : DROP_W'(s);
  endfunction
endpackage

// File: rtl/evlog_fifo.sv
// evlog_fifo: show-ahead record FIFO, push allowed while full when a pop happens on the same edge
module evlog_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_do_pop, w_do_push;
  assign o_empty   = r_wp == r_rp;
  assign o_full    = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
  // read/write pointers with a wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop) r_rp <= r_rp + 1'b1;
    end
  // storage needs no reset; empty masks stale contents at the output
  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/change_event_logger.sv
// change_event_logger: timestamps per-bit changes of sig_in and queues them lowest index first
module change_event_logger
  import evlog_pkg::*;
#(
  parameter int NSIG  = DEF_NSIG,
  parameter int TS_W  = DEF_TS_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = $clog2(NSIG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NSIG-1:0]   sig_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [TS_W-1:0]   ev_time,
  output logic [IDX_W-1:0]  ev_index,
  output logic              ev_value,
  output logic              dropped,
  output logic [DROP_W-1:0] drop_count,
  input  logic              clear_drop
);
  localparam int REC_W = TS_W + IDX_W + 1;
  logic [TS_W-1:0]   r_ts_cnt;
  logic [TS_W-1:0]   r_ts [NSIG];
  logic [NSIG-1:0]   r_prev, r_pend, r_val;
  logic              r_primed, r_dropped;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [NSIG-1:0]   w_chg, w_hit, w_set, w_drop;
  logic [IDX_W-1:0]  w_sel;
  logic [31:0]       w_ndrop;
  logic              w_push, w_pop, w_full, w_empty;
  logic [REC_W-1:0]  w_rec_in, w_rec_out;
  assign w_chg    = (enable & r_primed) ? (sig_in ^ r_prev) : '0;
  assign w_pop    = ev_valid & ev_ready;
  assign w_push   = (|r_pend) & (~w_full | w_pop);
  assign w_hit    = w_push ? (NSIG'(1) << w_sel) : '0;
  assign w_set    = w_chg & (~r_pend | w_hit);
  assign w_drop   = w_chg & r_pend & ~w_hit;
  assign w_ndrop  = 32'($countones(w_drop));
  assign w_rec_in = {r_ts[w_sel], w_sel, r_val[w_sel]};
  assign ev_valid = ~w_empty;
  assign {ev_time, ev_index, ev_value} = w_rec_out;
  assign dropped    = r_dropped;
  assign drop_count = r_drop_cnt;
  // priority encoder: lowest pending index drains first
  always_comb begin
    w_sel = '0;
    for (int i = NSIG - 1; i >= 0; i--) if (r_pend[i]) w_sel = IDX_W'(i);
  end
  // timestamp counter, change detector history and pending set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ts_cnt <= '0;
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_pend   <= '0;
      r_val    <= '0;
    end else begin
      if (enable) r_ts_cnt <= r_ts_cnt + 1'b1;
      r_prev   <= sig_in;
      r_primed <= r_primed | enable;
      r_pend   <= (r_pend & ~w_hit) | w_set;
      r_val    <= (r_val & ~w_set) | (sig_in & w_set);
    end
  // per-bit capture of the timestamp at which a pending change was seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NSIG; i++) r_ts[i] <= '0;
    end else begin
      for (int i = 0; i < NSIG; i++) if (w_set[i]) r_ts[i] <= r_ts_cnt;
    end
  // sticky drop flag and saturating count; a same-cycle drop overrides clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dropped  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (|w_drop) begin
      r_dropped  <= 1'b1;
      r_drop_cnt <= drop_add(clear_drop ? '0 : r_drop_cnt, w_ndrop);
    end else if (clear_drop) begin
      r_dropped  <= 1'b0;
      r_drop_cnt <= '0;
    end
  evlog_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec_in),
    .o_data  (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_change_event_logger.sv
// tb_change_event_logger: directed stimulus with queued expected records checked by output monitors
module tb_change_event_logger;
  import evlog_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ev_ready = 1'b0, clear_drop = 1'b0;
  logic [11:0] sig = 12'h0FF, sig2 = 12'h000;
  logic        ev_valid, ev_value, dropped;
  logic [15:0] ev_time;
  logic [3:0]  ev_index;
  logic [7:0]  drop_count;
  logic        e2_valid, e2_value, e2_dropped;
  logic [3:0]  e2_time, e2_index;
  logic [7:0]  e2_count;
  int          n_chk = 0, n_err = 0;
  logic [15:0] tb_ts = '0;
  ev_rec_t     q[$];
  logic [8:0]  q2[$];

  always #5 clk = ~clk;

  change_event_logger dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time), .ev_index(ev_index),
    .ev_value(ev_value), .dropped(dropped), .drop_count(drop_count), .clear_drop(clear_drop)
  );

  change_event_logger #(.TS_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig2),
    .ev_valid(e2_valid), .ev_ready(1'b1), .ev_time(e2_time), .ev_index(e2_index),
    .ev_value(e2_value), .dropped(e2_dropped), .drop_count(e2_count), .clear_drop(1'b0)
  );

  always @(negedge clk) begin
    ev_rec_t e;
    if (rst_n && ev_valid && ev_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rec unexpected: got t=%0d i=%0d v=%0b, none required", ev_time, ev_index, ev_value);
      end else begin
        e = q.pop_front();
        if ({ev_time, ev_index, ev_value} !== e) begin
          n_err++;
          $display("FAIL rec: got t=%0d i=%0d v=%0b, required t=%0d i=%0d v=%0b",
                   ev_time, ev_index, ev_value, e.t, e.index, e.value);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && e2_valid) begin
      n_chk++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL rec4 unexpected: got t=%0d i=%0d v=%0b", e2_time, e2_index, e2_value);
      end else begin
        e = q2.pop_front();
        if ({e2_time, e2_index, e2_value} !== e) begin
          n_err++;
          $display("FAIL rec4: got t=%0d i=%0d v=%0b, required t=%0d i=%0d v=%0b",
                   e2_time, e2_index, e2_value, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) tb_ts = '0;
    else if (enable) tb_ts = tb_ts + 1'b1;
    #1;
  endtask

  task automatic toggle(input logic [11:0] m, input bit expect_rec);
    sig = sig ^ m;
    if (expect_rec)
      for (int i = 0; i < 12; i++)
        if (m[i]) q.push_back(ev_rec_t'{t: tb_ts, index: 4'(i), value: sig[i]});
  endtask

  initial begin
    enable = 1'b1;
    ev_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", ev_valid, 0);
    chk("rst_time", ev_time, 0);
    chk("rst_index", ev_index, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_count", drop_count, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("prime_no_record", ev_valid, 0);
    // bit 3 falls, sampled at ts=5
    toggle(12'h008, 1'b1);
    tick();
    chk("lat_edge1_valid", ev_valid, 0);
    tick();
    chk("lat_edge2_valid", ev_valid, 1);
    chk("lat_time", ev_time, 5);
    chk("lat_index", ev_index, 3);
    toggle(12'h081, 1'b1);
    for (int i = 0; i < 40 && tb_ts != 16'd20; i++) tick();
    // bits 0, 7, 11 rise together at ts=20
    toggle(12'h881, 1'b1);
    tick();
    tick();
    chk("multi_v0", ev_valid, 1);
    chk("multi_t0", ev_time, 20);
    chk("multi_i0", ev_index, 0);
    tick();
    chk("multi_v1", ev_valid, 1);
    chk("multi_i1", ev_index, 7);
    tick();
    chk("multi_v2", ev_valid, 1);
    chk("multi_i2", ev_index, 11);
    tick();
    chk("multi_v3", ev_valid, 0);
    // timestamp wrap on the 4-bit instance
    for (int i = 0; i < 20 && tb_ts[3:0] != 4'd15; i++) tick();
    sig2 = sig2 ^ 12'h004;
    q2.push_back({4'd15, 4'd2, sig2[2]});
    tick();
    tick();
    sig2 = sig2 ^ 12'h004;
    q2.push_back({4'd1, 4'd2, sig2[2]});
    for (int i = 0; i < 4; i++) tick();
    // backpressure: fill the FIFO, then drop on the still-pending bit
    ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      toggle(12'h001, 1'b1);
      tick();
    end
    chk("full_no_drop", dropped, 0);
    chk("full_head_idx", ev_index, 0);
    toggle(12'h001, 1'b0);
    tick();
    chk("drop_flag", dropped, 1);
    chk("drop_cnt1", drop_count, 1);
    toggle(12'h006, 1'b1);
    tick();
    chk("pend_no_drop", drop_count, 1);
    toggle(12'h007, 1'b0);
    tick();
    chk("multi_drop_cnt", drop_count, 4);
    toggle(12'h001, 1'b0);
    clear_drop = 1'b1;
    tick();
    chk("clr_vs_drop_flag", dropped, 1);
    chk("clr_vs_drop_cnt", drop_count, 1);
    tick();
    chk("clr_flag", dropped, 0);
    chk("clr_cnt", drop_count, 0);
    clear_drop = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("drain_done", q.size(), 0);
    // disabled window: prior pending record drains, toggles ignored, ts frozen
    toggle(12'h020, 1'b1);
    tick();
    enable = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) toggle(12'h040, 1'b0);
      tick();
    end
    enable = 1'b1;
    tick();
    toggle(12'h010, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    // reset while the FIFO holds five records
    ev_ready = 1'b0;
    toggle(12'h01F, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_valid", ev_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ev_valid, 0);
    chk("async_rst_time", ev_time, 0);
    chk("async_rst_index", ev_index, 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("reprime_no_record", ev_valid, 0);
    toggle(12'h100, 1'b1);
    for (int i = 0; i < 100 && (q.size() != 0 || q2.size() != 0); i++) tick();
    chk("final_q", q.size(), 0);
    chk("final_q4", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
